// File: rtl/ippro_stream_fifo_pkg.sv
// ippro_stream_fifo_pkg: shared widths and threshold defaults for the IPPro input FIFO
package ippro_stream_fifo_pkg;
  localparam int FIFO_DATASIZE = 16;
  localparam int FIFO_ADDRSIZE = 4;
  localparam int AFULL_TH_DEF = 14;
  localparam int AEMPTY_TH_DEF = 2;
endpackage

// File: rtl/ippro_stream_fifo_if.sv
// ippro_stream_fifo_if: push side, pop side and status of the IPPro input FIFO
interface ippro_stream_fifo_if import ippro_stream_fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATASIZE,
  parameter int ADDR_W = FIFO_ADDRSIZE
) ();
  logic [DATA_W-1:0] FIFO_IN;
  logic WRITE_EN;
  logic FULL;
  logic ALMOST_FULL;
  logic READ_EN;
  logic [DATA_W-1:0] DOUT;
  logic DValid;
  logic EMPTY;
  logic ALMOST_EMPTY;
  logic [ADDR_W:0] COUNT;
  logic OVERFLOW;
  logic UNDERFLOW;
  logic CLR_ERR;
  modport master (
    output FIFO_IN, WRITE_EN, READ_EN, CLR_ERR,
    input FULL, ALMOST_FULL, DOUT, DValid, EMPTY, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input FIFO_IN, WRITE_EN, READ_EN, CLR_ERR,
    output FULL, ALMOST_FULL, DOUT, DValid, EMPTY, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/ippro_fifo_ram.sv
// ippro_fifo_ram: simple dual-port RAM, synchronous write, registered read (old data on collision)
module ippro_fifo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/ippro_stream_fifo.sv
// ippro_stream_fifo: input-stage stream FIFO feeding the IPPro core get/READ_EN/EMPTY/DIN port
module ippro_stream_fifo import ippro_stream_fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATASIZE,
  parameter int ADDR_W = FIFO_ADDRSIZE,
  parameter int AFULL_TH = AFULL_TH_DEF,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input logic CLK,
  input logic RESET,
  ippro_stream_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] AF_TH = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(AEMPTY_TH);
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic push, pop;
  logic [DATA_W-1:0] dout;
  // a pop at FULL frees the slot the simultaneous push lands in
  always_comb begin
    pop = bus.READ_EN && !bus.EMPTY;
    push = bus.WRITE_EN && (!bus.FULL || bus.READ_EN);
    wr_nxt = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    cnt_nxt = wr_nxt - rd_nxt;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.COUNT <= '0;
      bus.EMPTY <= 1'b1;
      bus.ALMOST_EMPTY <= 1'b1;
      bus.FULL <= 1'b0;
      bus.ALMOST_FULL <= 1'b0;
      bus.DValid <= 1'b0;
      bus.OVERFLOW <= 1'b0;
      bus.UNDERFLOW <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      bus.COUNT <= cnt_nxt;
      bus.EMPTY <= wr_nxt == rd_nxt;
      bus.FULL <= wr_nxt[ADDR_W] != rd_nxt[ADDR_W] && wr_nxt[ADDR_W-1:0] == rd_nxt[ADDR_W-1:0];
      bus.ALMOST_EMPTY <= cnt_nxt <= AE_TH;
      bus.ALMOST_FULL <= cnt_nxt >= AF_TH;
      bus.DValid <= pop;
      bus.OVERFLOW <= (bus.WRITE_EN && bus.FULL && !bus.READ_EN) || (bus.OVERFLOW && !bus.CLR_ERR);
      bus.UNDERFLOW <= (bus.READ_EN && bus.EMPTY) || (bus.UNDERFLOW && !bus.CLR_ERR);
    end
  ippro_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(CLK),
    .rst_n(RESET),
    .we(push),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(bus.FIFO_IN),
    .re(pop),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(dout)
  );
  assign bus.DOUT = dout;
endmodule

// File: tb/tb_ippro_stream_fifo.sv
// tb_ippro_stream_fifo: scenario tasks checked against a queue-based reference model
module tb_ippro_stream_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  ippro_stream_fifo_if bus ();
  ippro_stream_fifo dut (.CLK(clk), .RESET(rst_n), .bus(bus));
  int passed = 0;
  int total = 0;
  logic [15:0] q[$];
  logic [15:0] m_dout;
  logic m_dv, m_ovf, m_unf;
  function automatic logic [27:0] exp_vec();
    int n = q.size();
    return {5'(n), n == 16, n >= 14, n == 0, n <= 2, m_dv, m_ovf, m_unf, m_dout};
  endfunction
  function automatic logic [27:0] act_vec();
    return {bus.COUNT, bus.FULL, bus.ALMOST_FULL, bus.EMPTY, bus.ALMOST_EMPTY,
            bus.DValid, bus.OVERFLOW, bus.UNDERFLOW, bus.DOUT};
  endfunction
  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask
  task automatic cyc(input logic we, input logic re, input logic [15:0] din, input logic clr);
    bit full, empty, pop, push;
    bus.WRITE_EN = we;
    bus.READ_EN = re;
    bus.FIFO_IN = din;
    bus.CLR_ERR = clr;
    @(posedge clk);
    full = q.size() == 16;
    empty = q.size() == 0;
    pop = re && !empty;
    push = we && (!full || re);
    m_dv = pop;
    if (pop) m_dout = q.pop_front();
    if (push) q.push_back(din);
    m_ovf = (we && full && !re) || (m_ovf && !clr);
    m_unf = (re && empty) || (m_unf && !clr);
    #1;
  endtask
  task automatic test_reset();
    bus.WRITE_EN = 0; bus.READ_EN = 0; bus.FIFO_IN = 0; bus.CLR_ERR = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_async: got %h want %h", act_vec(), exp_vec());
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0, 0);
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL reset_idle: got %h want %h", act_vec(), exp_vec());
      else passed++;
    end
    cyc(0, 1, 16'h0, 0);
    total++;
    if (bus.UNDERFLOW !== 1'b1 || bus.DValid !== 1'b0)
      $display("FAIL reset_underflow: got unf=%b dv=%b want unf=1 dv=0", bus.UNDERFLOW, bus.DValid);
    else passed++;
  endtask
  task automatic test_order();
    logic [15:0] vals [4] = '{16'd2, 16'd30, 16'd40, 16'd50};
    cyc(0, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, vals[i], 0);
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL order_push%0d: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 16'h0, 0);
      total++;
      if (bus.DOUT !== vals[i] || bus.DValid !== 1'b1 || bus.COUNT !== 5'(3 - i))
        $display("FAIL order_pop%0d: got dout=%h dv=%b cnt=%0d want dout=%h dv=1 cnt=%0d",
                 i, bus.DOUT, bus.DValid, bus.COUNT, vals[i], 3 - i);
      else passed++;
    end
    total++;
    if (bus.EMPTY !== 1'b1) $display("FAIL order_empty: got %b want 1", bus.EMPTY);
    else passed++;
  endtask
  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 16'(i), 0);
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL fill_push%0d: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
    cyc(1, 0, 16'hDEAD, 0);
    total++;
    if (bus.OVERFLOW !== 1'b1 || bus.COUNT !== 5'd16 || bus.FULL !== 1'b1)
      $display("FAIL fill_overflow: got ovf=%b cnt=%0d full=%b want ovf=1 cnt=16 full=1",
               bus.OVERFLOW, bus.COUNT, bus.FULL);
    else passed++;
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 16'h0, 0);
      total++;
      if (bus.DOUT !== 16'(i) || act_vec() !== exp_vec())
        $display("FAIL fill_drain%0d: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
    cyc(0, 0, 16'h0, 1);
  endtask
  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) cyc(1, 0, 16'($urandom), 0);
    cyc(1, 1, 16'h07FE, 0);
    total++;
    if (bus.COUNT !== 5'd16 || bus.OVERFLOW !== 1'b0 || act_vec() !== exp_vec())
      $display("FAIL full_rw: got %h want %h", act_vec(), exp_vec());
    else passed++;
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 16'h0, 0);
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL full_rw_drain%0d: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (bus.DOUT !== 16'h07FE) $display("FAIL full_rw_last: got %h want 07fe", bus.DOUT);
    else passed++;
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, 16'($urandom), 0);
      total++;
      if (bus.COUNT !== 5'd3 || act_vec() !== exp_vec())
        $display("FAIL b2b%0d: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0, 0);
  endtask
  task automatic test_empty_rw();
    cyc(1, 1, 16'h0100, 0);
    total++;
    if (bus.UNDERFLOW !== 1'b1 || bus.COUNT !== 5'd1 || bus.DValid !== 1'b0)
      $display("FAIL empty_rw: got unf=%b cnt=%0d dv=%b want unf=1 cnt=1 dv=0",
               bus.UNDERFLOW, bus.COUNT, bus.DValid);
    else passed++;
    cyc(0, 1, 16'h0, 0);
    total++;
    if (bus.DOUT !== 16'h0100 || bus.DValid !== 1'b1)
      $display("FAIL empty_rw_pop: got dout=%h dv=%b want dout=0100 dv=1", bus.DOUT, bus.DValid);
    else passed++;
    cyc(0, 1, 16'h0, 1);
    total++;
    if (bus.UNDERFLOW !== 1'b1) $display("FAIL clr_vs_set: got unf=%b want 1", bus.UNDERFLOW);
    else passed++;
    for (int i = 0; i < 5; i++) cyc(1, 0, 16'($urandom), 0);
    cyc(1, 1, 16'($urandom), 0);
    #2 rst_n = 1'b0;
    bus.WRITE_EN = 0; bus.READ_EN = 0; bus.CLR_ERR = 0;
    model_reset();
    #1;
    total++;
    if (bus.COUNT !== 5'd0 || bus.DValid !== 1'b0 || bus.EMPTY !== 1'b1 || act_vec() !== exp_vec())
      $display("FAIL midreset: got %h want %h", act_vec(), exp_vec());
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 1, 16'h0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 0, 16'($urandom), 0);
    total++;
    if (bus.OVERFLOW !== 1'b1 || bus.UNDERFLOW !== 1'b1)
      $display("FAIL errs_set: got ovf=%b unf=%b want 1 1", bus.OVERFLOW, bus.UNDERFLOW);
    else passed++;
    cyc(0, 0, 16'h0, 1);
    total++;
    if (bus.OVERFLOW !== 1'b0 || bus.UNDERFLOW !== 1'b0)
      $display("FAIL clr_err: got ovf=%b unf=%b want 0 0", bus.OVERFLOW, bus.UNDERFLOW);
    else passed++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 15) == 0);
      total++;
      if (act_vec() !== exp_vec()) $display("FAIL random%0d: got %h want %h", i, act_vec(), exp_vec());
      else passed++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_order();
    test_fill();
    test_full_rw();
    test_back_to_back();
    test_empty_rw();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ippro_stream_fifo.md
Name: ippro_stream_fifo

Overview:
- Input-stage stream FIFO feeding an IPPro core. It is the producer end of the core's get/READ_EN/EMPTY/DIN interface.
- Upstream (pixel source or previous stage WRITE_EN/DOUT/FULL) pushes words in; the core pops them with READ_EN and receives data on DIN.
- Provides occupancy, almost-empty/almost-full and sticky error flags for the stream controller.

Parameters:
DATA_W, 16, word width; equals `FIFO_datasize.
ADDR_W, 4, log2 depth; DEPTH = 2**ADDR_W = 16 words.
AFULL_TH, 14, ALMOST_FULL asserted when COUNT >= AFULL_TH.
AEMPTY_TH, 2, ALMOST_EMPTY asserted when COUNT <= AEMPTY_TH.

Ports:
CLK  in  1  clock, all logic rising-edge.
RESET  in  1  asynchronous, active-low reset.
FIFO_IN  in  DATA_W  upstream write data.
WRITE_EN  in  1  upstream push request.
FULL  out  1  no space; upstream must not push.
ALMOST_FULL  out  1  COUNT >= AFULL_TH.
READ_EN  in  1  core pop request (core READ_EN).
DOUT  out  DATA_W  read data to core DIN.
DValid  out  1  DOUT holds a freshly popped word this cycle.
EMPTY  out  1  no data; core must stall its get.
ALMOST_EMPTY  out  1  COUNT <= AEMPTY_TH.
COUNT  out  ADDR_W+1  occupancy, 0..DEPTH.
OVERFLOW  out  1  sticky: push attempted while FULL.
UNDERFLOW  out  1  sticky: pop attempted while EMPTY.
CLR_ERR  in  1  synchronous clear of OVERFLOW/UNDERFLOW.

Behaviour:
- Reset (RESET=0, asynchronous): wr_ptr=rd_ptr=0, COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0, DOUT=0, DValid=0, OVERFLOW=0, UNDERFLOW=0. Storage RAM is not reset.
- Pointers: ADDR_W+1 bits, with the extra MSB as the wrap bit.
  - EMPTY when the pointers are equal.
  - FULL when the low bits are equal and the MSBs differ.
  - All flags are registered and valid in the cycle after the edge that changed COUNT.
- Push: effective when WRITE_EN && !FULL. mem[wr_ptr] <= FIFO_IN, wr_ptr++. Wraps modulo 2*DEPTH with no special case.
- Pop: effective when READ_EN && !EMPTY. DOUT <= mem[rd_ptr], rd_ptr++.
  - DValid=1 the cycle after an effective pop, else 0. Read latency is 1 clock.
  - DOUT holds its last value when no pop occurs.
- Simultaneous push and pop:
  - Both effective when !EMPTY && !FULL.
  - When FULL, both are effective: the pop frees a slot in the same edge, so the write is accepted and COUNT is unchanged.
  - When EMPTY, only the push is effective. The pop is rejected, UNDERFLOW sets, and no bypass occurs: the new word is readable the next cycle.
- COUNT: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- Error flags:
  - WRITE_EN && FULL && !READ_EN sets OVERFLOW; the data is dropped.
  - READ_EN && EMPTY sets UNDERFLOW; DValid stays 0.
  - Both flags stay set until CLR_ERR=1 or reset. If CLR_ERR and a new error occur in the same cycle, set wins.
- Reset mid-stream: all pointers are cleared immediately and contents are discarded. DValid drops asynchronously.
- Single-state datapath with no FSM. Sequential behaviour is pointer, counter and flag registers only.

Decomposition:
- Shared package/include (parameters.v): `FIFO_datasize, default depth `FIFO_addrsize, threshold defaults.
- One sub-module, ippro_fifo_ram: simple dual-port RAM (DEPTH x DATA_W) with a synchronous write port and a registered synchronous read port, so synthesis can infer distributed or block RAM.
- Pointer, flag and counter logic stays in ippro_stream_fifo.

Test Plan:
- Reset then idle -> EMPTY=1, FULL=0, COUNT=0, DValid=0 throughout. Pulse READ_EN -> UNDERFLOW=1, DValid=0.
- Push 2,30,40,50 then pop four times -> DOUT sequence 2,30,40,50, each with DValid one cycle after READ_EN. COUNT goes 4,3,2,1,0, then EMPTY=1.
- Fill with 16 words (0x0001..0x0010) -> FULL=1 at COUNT=16, ALMOST_FULL from COUNT=14. A 17th push -> OVERFLOW=1 and COUNT stays 16. Drain -> reads 0x0001..0x0010, proving no corruption.
- At FULL, assert WRITE_EN and READ_EN together with FIFO_IN=0x07FE -> COUNT stays 16, no OVERFLOW, and 0x07FE emerges as the 16th subsequent read.
- Run 40 continuous push+pop cycles starting at COUNT=3 -> COUNT stays 3, and data order is preserved across two pointer wraps.
- At EMPTY, apply WRITE_EN+READ_EN with 0x0100 -> UNDERFLOW=1, COUNT=1, and the next pop returns 0x0100. Assert RESET=0 mid-burst -> all outputs return to reset values in the same cycle. Then CLR_ERR -> both error flags are 0.
